// File: rtl/cls_pkg.sv
// Shared constants for the classification head: widths, FSM states and the
// per-class linear-score coefficients.
package cls_pkg;

  localparam int SUM_W   = 15;
  localparam int SCORE_W = 29;
  localparam int COEF_W  = 11;
  localparam int N_CLS   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_SCORE,
    S_ARGMAX,
    S_HOLD
  } state_t;

  // Coefficients are positive magnitudes; 1066 needs all 11 bits unsigned.
  function automatic logic [COEF_W-1:0] kp(input logic [2:0] c);
    case (c)
      3'd0:    return 11'd399;
      3'd1:    return 11'd711;
      3'd2:    return 11'd651;
      3'd3:    return 11'd671;
      3'd4:    return 11'd1066;
      default: return '0;
    endcase
  endfunction

  function automatic logic [COEF_W-1:0] kn(input logic [2:0] c);
    case (c)
      3'd0:    return 11'd142;
      3'd1:    return 11'd253;
      3'd2:    return 11'd231;
      3'd3:    return 11'd238;
      3'd4:    return 11'd379;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [SCORE_W-1:0] bias(input logic [2:0] c);
    case (c)
      3'd0:    return 29'sd72144;
      3'd1:    return 29'sd79299;
      3'd2:    return -29'sd42039;
      3'd3:    return -29'sd221157;
      3'd4:    return -29'sd209655;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/cls_mac.sv
// Shared two-stage multiply-accumulate: registered 15x11 product, then a
// 29-bit accumulate with optional addend. Emits a tagged score on completion.
module cls_mac
  import cls_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue,
  input  logic                      acc_en,
  input  logic                      last,
  input  logic [2:0]                ch,
  input  logic signed [SUM_W-1:0]   a,
  input  logic [COEF_W-1:0]         k,
  input  logic signed [SCORE_W-1:0] addend,
  output logic                      score_vld,
  output logic [2:0]                score_ch,
  output logic signed [SCORE_W-1:0] score
);

  localparam int PROD_W = SUM_W + COEF_W + 1;

  logic signed [PROD_W-1:0]  a_x, k_x, prod_x;
  logic signed [PROD_W-1:0]  prod_p0;
  logic signed [SCORE_W-1:0] addend_p0, prod_ext, acc_p1;
  logic                      vld_p0, acc_en_p0, last_p0, vld_p1;
  logic [2:0]                ch_p0, ch_p1;

  assign a_x    = {{(PROD_W-SUM_W){a[SUM_W-1]}}, a};
  assign k_x    = {{(PROD_W-COEF_W){1'b0}}, k};
  assign prod_x = a_x * k_x;

  // stage p0: registered product
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= issue;
  end

  always_ff @(posedge clk) begin
    prod_p0   <= prod_x;
    addend_p0 <= addend;
    acc_en_p0 <= acc_en;
    last_p0   <= last;
    ch_p0     <= ch;
  end

  // stage p1: accumulate
  assign prod_ext = {{(SCORE_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};

  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0 & last_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      acc_p1 <= (acc_en_p0 ? acc_p1 : '0) + prod_ext + addend_p0;
      ch_p1  <= ch_p0;
    end
  end

  assign score_vld = vld_p1;
  assign score_ch  = ch_p1;
  assign score     = acc_p1;

endmodule

// File: rtl/cls_head_sched.sv
// Classification head: accumulates pooled features per class, scores them
// through one shared MAC and picks the argmax. Option: CLS_SCORE_OUT_EN.
module cls_head_sched
  import cls_pkg::*;
#(
  parameter int N_CH   = 5,
  parameter int N_FEAT = 27,
  parameter int FEAT_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      feat_val,
  input  logic [2:0]                feat_ch,
  input  logic signed [FEAT_W-1:0]  feat_data,
  output logic                      busy,
  output logic                      cls_valid,
  input  logic                      cls_ready,
  output logic [2:0]                cls,
  output logic                      ch_err
`ifdef CLS_SCORE_OUT_EN
  ,
  output logic signed [SCORE_W-1:0] cls_score
`endif
);

  localparam int         N_BEATS = N_CH * N_FEAT;
  localparam int         CNT_W   = $clog2(N_BEATS + 1);
  localparam logic [2:0] N_CH_L  = 3'(N_CH);

  state_t state_q, state_d;

  logic signed [SUM_W-1:0]   pos_q [N_CH];
  logic signed [SUM_W-1:0]   neg_q [N_CH];
  logic signed [SCORE_W-1:0] y_q   [N_CH];
  logic signed [SCORE_W-1:0] best_q;
  logic signed [SUM_W-1:0]   feat_x;
  logic [CNT_W-1:0]          beat_cnt_q;
  logic [3:0]                sc_cnt_q;
  logic [2:0]                am_cnt_q, best_idx_q, pick;
  logic [2:0]                cls_q;
  logic                      cls_valid_q, ch_err_q;
  logic                      beat_ok, last_beat, take;

  logic                      mac_issue, mac_phase, score_vld;
  logic [2:0]                mac_ch, score_ch;
  logic signed [SUM_W-1:0]   mac_a;
  logic [COEF_W-1:0]         mac_k;
  logic signed [SCORE_W-1:0] mac_add, score;

  assign feat_x    = {{(SUM_W-FEAT_W){feat_data[FEAT_W-1]}}, feat_data};
  assign beat_ok   = (state_q == S_ACCUM) && feat_val && (feat_ch < N_CH_L);
  assign last_beat = beat_ok && (beat_cnt_q == CNT_W'(N_BEATS - 1));

  // One ARGMAX step: strictly greater replaces, so ties keep the lower index.
  assign take = (am_cnt_q == 3'd0) || (y_q[am_cnt_q] > best_q);
  assign pick = take ? am_cnt_q : best_idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // SCORE runs 10 MAC issues plus one drain cycle for the product register.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)                    state_d = S_ACCUM;
      S_ACCUM:  if (last_beat)                state_d = S_SCORE;
      S_SCORE:  if (sc_cnt_q == 4'd10)        state_d = S_ARGMAX;
      S_ARGMAX: if (am_cnt_q == 3'd4)         state_d = S_HOLD;
      S_HOLD:   if (cls_valid_q && cls_ready) state_d = S_IDLE;
      default:                                state_d = S_IDLE;
    endcase
  end

  // Even issue: pos term restarts the accumulator; odd issue: neg term + bias.
  always_comb begin
    mac_issue = (state_q == S_SCORE) && (sc_cnt_q < 4'd10);
    mac_ch    = mac_issue ? sc_cnt_q[3:1] : 3'd0;
    mac_phase = sc_cnt_q[0];
    mac_a     = pos_q[mac_ch];
    mac_k     = kp(mac_ch);
    mac_add   = '0;
    if (mac_phase) begin
      mac_a   = neg_q[mac_ch];
      mac_k   = kn(mac_ch);
      mac_add = bias(mac_ch);
    end
  end

  cls_mac u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (mac_issue),
    .acc_en    (mac_phase),
    .last      (mac_phase),
    .ch        (mac_ch),
    .a         (mac_a),
    .k         (mac_k),
    .addend    (mac_add),
    .score_vld (score_vld),
    .score_ch  (score_ch),
    .score     (score)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      sc_cnt_q    <= '0;
      am_cnt_q    <= '0;
      ch_err_q    <= 1'b0;
      cls_q       <= '0;
      cls_valid_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        pos_q[c] <= '0;
        neg_q[c] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          beat_cnt_q <= '0;
          sc_cnt_q   <= '0;
          am_cnt_q   <= '0;
          ch_err_q   <= 1'b0;
          for (int c = 0; c < N_CH; c++) begin
            pos_q[c] <= '0;
            neg_q[c] <= '0;
          end
        end
        S_ACCUM: begin
          if (feat_val && !beat_ok) ch_err_q <= 1'b1;
          if (beat_ok) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (feat_data[FEAT_W-1]) neg_q[feat_ch] <= neg_q[feat_ch] + feat_x;
            else                     pos_q[feat_ch] <= pos_q[feat_ch] + feat_x;
          end
        end
        S_SCORE:  sc_cnt_q <= (sc_cnt_q == 4'd10) ? 4'd0 : sc_cnt_q + 1'b1;
        S_ARGMAX: begin
          am_cnt_q <= (am_cnt_q == 3'd4) ? 3'd0 : am_cnt_q + 1'b1;
          if (am_cnt_q == 3'd4) begin
            cls_q       <= pick;
            cls_valid_q <= 1'b1;
          end
        end
        S_HOLD: if (cls_ready) cls_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (score_vld) y_q[score_ch] <= score;
    if (state_q == S_ARGMAX && take) begin
      best_q     <= y_q[am_cnt_q];
      best_idx_q <= am_cnt_q;
    end
  end

`ifdef CLS_SCORE_OUT_EN
  logic signed [SCORE_W-1:0] score_q;

  always_ff @(posedge clk) begin
    if (state_q == S_ARGMAX && am_cnt_q == 3'd4)
      score_q <= take ? y_q[am_cnt_q] : best_q;
  end

  assign cls_score = score_q;
`endif

  assign busy      = (state_q != S_IDLE);
  assign cls_valid = cls_valid_q;
  assign cls       = cls_q;
  assign ch_err    = ch_err_q;

endmodule

// File: tb/tb_cls_head_sched.sv
// Directed bench for cls_head_sched: a reference score model fills a queue of
// expected classes that is drained as results appear.
module tb_cls_head_sched;

  logic              clk = 1'b0;
  logic              rst_n, start, feat_val, cls_ready;
  logic [2:0]        feat_ch;
  logic signed [9:0] feat_data;
  logic              busy, cls_valid, ch_err;
  logic [2:0]        cls;
`ifdef CLS_SCORE_OUT_EN
  logic signed [28:0] cls_score;
`endif

  typedef struct {
    int cls;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int KP[5]   = '{399, 711, 651, 671, 1066};
  int KN[5]   = '{142, 253, 231, 238, 379};
  int BIAS[5] = '{72144, 79299, -42039, -221157, -209655};

  cls_head_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .feat_val  (feat_val),
    .feat_ch   (feat_ch),
    .feat_data (feat_data),
    .busy      (busy),
    .cls_valid (cls_valid),
    .cls_ready (cls_ready),
    .cls       (cls),
    .ch_err    (ch_err)
`ifdef CLS_SCORE_OUT_EN
    ,
    .cls_score (cls_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int beat_val(input int mode, input int ch);
    case (mode)
      1:       return (ch == 0) ? 511 : 0;
      2:       return (ch == 4) ? 511 : ((ch == 1) ? -512 : 0);
      3:       return int'($urandom_range(0, 1023)) - 512;
      default: return 0;
    endcase
  endfunction

  // Drives one full frame and pushes the model's expected class.
  task automatic run_frame(input int mode, input int n_bad);
    int   pos[5] = '{0, 0, 0, 0, 0};
    int   neg[5] = '{0, 0, 0, 0, 0};
    int   bad_left = n_bad;
    int   v, y, best, bi;
    exp_t e;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("err_clear", ch_err, 0);
    for (int i = 0; i < 135; i++) begin
      if (bad_left > 0 && (i % 40) == 10) begin
        feat_val  = 1'b1;
        feat_ch   = 3'd6;
        feat_data = 10'sd200;
        tick();
        bad_left--;
      end
      v         = beat_val(mode, i % 5);
      feat_val  = 1'b1;
      feat_ch   = 3'(i % 5);
      feat_data = 10'(v);
      if (v < 0) neg[i % 5] += v;
      else       pos[i % 5] += v;
      tick();
    end
    feat_val = 1'b0;
    best = 0;
    bi   = 0;
    for (int c = 0; c < 5; c++) begin
      y = pos[c] * KP[c] + neg[c] * KN[c] + BIAS[c];
      if (c == 0 || y > best) begin
        best = y;
        bi   = c;
      end
    end
    e.cls = bi;
    e.err = (n_bad > 0);
    exp_q.push_back(e);
  endtask

  // Waits for the result, checks latency and value, optionally stalls the handshake.
  task automatic collect(input int hold);
    int   n = 0;
    exp_t e;
    while (!cls_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, 16);
    e = exp_q.pop_front();
    chk("cls", cls, e.cls);
    chk("ch_err", ch_err, e.err);
    chk("hold_busy0", busy, 1);
    for (int i = 0; i < hold; i++) begin
      start = (i == 5);
      tick();
      start = 1'b0;
      chk("hold_valid", cls_valid, 1);
      chk("hold_cls", cls, e.cls);
      chk("hold_busy", busy, 1);
    end
    cls_ready = 1'b1;
    tick();
    cls_ready = 1'b0;
    chk("idle_after", busy, 0);
    chk("valid_drop", cls_valid, 0);
    tick();
    chk("start_ignored", busy, 0);
    chk("err_sticky", ch_err, e.err);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    start     = 1'b0;
    feat_val  = 1'b0;
    feat_ch   = '0;
    feat_data = '0;
    cls_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", cls_valid, 0);
    chk("rst_cls", cls, 0);
    chk("rst_err", ch_err, 0);
    rst_n = 1'b1;
    tick();

    run_frame(0, 0);
    collect(0);
    run_frame(1, 0);
    collect(0);
    run_frame(2, 0);
    collect(20);
    run_frame(3, 0);
    collect(0);
    run_frame(3, 0);
    collect(3);
    run_frame(0, 3);
    collect(0);

    // Reset in the middle of a frame: nothing may come out.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 135; i++) begin
      rst_n     = (i != 70);
      feat_val  = 1'b1;
      feat_ch   = 3'(i % 5);
      feat_data = 10'sd100;
      tick();
      if (i == 70) begin
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", cls_valid, 0);
        chk("midrst_err", ch_err, 0);
      end
    end
    rst_n    = 1'b1;
    feat_val = 1'b0;
    seen     = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cls_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    chk("midrst_idle", busy, 0);

    run_frame(0, 0);
    collect(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cls_head_sched.md
CLS_HEAD_SCHED -- requirements
Module: cls_head_sched

Interface
REQ-001 SHALL have parameter N_CH, default 5, meaning number of class channels.
REQ-002 SHALL have parameter N_FEAT, default 27, meaning feature beats per channel per frame.
REQ-003 SHALL have parameter FEAT_W, default 10, meaning signed feature width.
REQ-004 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  frame-begin pulse; honoured only in IDLE.
REQ-007 SHALL have port feat_val  input  1  feature beat valid; no backpressure.
REQ-008 SHALL have port feat_ch  input  3  channel index of the beat.
REQ-009 SHALL have port feat_data  input  FEAT_W  signed max-pooled feature.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port cls_valid  output  1  class result valid.
REQ-012 SHALL have port cls_ready  input  1  consumer accepts the class.
REQ-013 SHALL have port cls  output  3  winning class index.
REQ-014 SHALL have port ch_err  output  1  sticky flag: beat with feat_ch >= N_CH seen this frame.

Function
REQ-015 SHALL implement FSM IDLE -> ACCUM (start) -> SCORE -> ARGMAX -> HOLD -> IDLE (cls_valid & cls_ready).
REQ-016 SHALL, on the IDLE->ACCUM edge, clear all sums, the beat counter and ch_err.
REQ-017 SHALL, in ACCUM, add each valid beat with feat_ch < N_CH to that channel's pos sum if feat_data[FEAT_W-1]==0, else to its neg sum.
REQ-018 SHALL hold the sums as 15-bit signed values; range is proven (27*511 = 13797), so no saturation.
REQ-019 SHALL ignore, not count, any beat with feat_ch >= N_CH, and set ch_err.
REQ-020 SHALL leave ACCUM on the edge that accepts beat number N_CH*N_FEAT (135); beats may arrive in any channel order.
REQ-021 SHALL compute, in SCORE, y[c] = pos[c]*KP[c] + neg[c]*KN[c] + BIAS[c] (29-bit signed) through one shared multiply-add.
REQ-022 SHALL spend 2 cycles per channel in ascending c (pos term, then neg term plus bias), 10 cycles total.
REQ-023 SHALL, in ARGMAX, scan y[0..4] with one comparison per cycle (5 cycles); a ties-to-lowest-index rule applies (strictly greater replaces).
REQ-024 SHALL register cls and raise cls_valid exactly 16 cycles after the edge that accepted the last beat.
REQ-025 SHALL hold cls and cls_valid stable in HOLD until cls_ready; the transfer occurs on the edge with both high, and IDLE is re-entered next cycle.
REQ-026 SHALL ignore start outside IDLE and ignore feat_val outside ACCUM.
REQ-027 SHALL keep ch_err readable in HOLD and IDLE until the next accepted start.

Reset
REQ-028 SHALL, when rst_n is low at a clock edge, force IDLE, busy=0, cls_valid=0, cls=0, ch_err=0, all sums and counters 0.
REQ-029 SHALL, when reset occurs mid-frame (any state), discard the frame without emitting a result.

Configuration
REQ-030 SHALL, when CLS_SCORE_OUT_EN is defined, add output cls_score (29-bit signed), equal to the winning y and valid with cls_valid.
REQ-031 SHALL, when CLS_SCORE_OUT_EN is undefined, omit the port and its register.

Structure
REQ-032 SHALL take the following from shared package cls_pkg: KP={399,711,651,671,1066}; KN={142,253,231,238,379}; BIAS={72144,79299,-42039,-221157,-209655}; the state enum; and the sum and score width constants.
REQ-033 SHALL instantiate sub-module cls_mac: a registered signed 15x11 multiply with 29-bit accumulate/bias-add, selected by the FSM.

Verification
REQ-034 SHALL cover: all 135 beats zero -> scores equal BIAS; cls=1 at cycle +16.
REQ-035 SHALL cover: ch0 all 27 beats +511, others 0 -> y0=5577147; cls=0.
REQ-036 SHALL cover: ch4 all +511, ch1 all -512 -> y4=14497947; cls=4.
REQ-037 SHALL cover: cls_ready held low 20 cycles with a start pulse during HOLD -> cls stable, busy=1, start ignored; IDLE one cycle after the handshake.
REQ-038 SHALL cover: rst_n low for 1 cycle at beat 70 -> IDLE, no cls_valid; the next full zero frame gives cls=1.
REQ-039 SHALL cover: 3 beats with feat_ch=6 interleaved with 135 zero beats -> ch_err=1, cls=1, timing unchanged.
